// File: rtl/countdown_timer.sv
// MM:SS countdown timer: loads a preset, counts down under start/stop/clear, flags expiry.
// Latency: controls act on the sampling edge and show one cycle later; all outputs are registered.
module countdown_timer #(
   parameter int CLKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_minutes,
   input  logic [5:0] load_seconds,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic [7:0] minutes,
   output logic [5:0] seconds,
   output logic [1:0] status,
   output logic       done
);

   localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUNNING = 2'b01,
      ST_PAUSED  = 2'b10,
      ST_EXPIRED = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;

   logic          count_zero;
   logic          tick;
   logic          load_ok;
   logic          start_ok;

   assign count_zero = (min_q == 8'd0) && (sec_q == 6'd0);
   assign tick       = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
   assign load_ok    = load && (state_q != ST_RUNNING);
   assign start_ok   = start && !count_zero &&
                       ((state_q == ST_IDLE) || (state_q == ST_PAUSED));

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      presc_d = presc_q;
      done_d  = 1'b0;

      if (clear) begin
         state_d = ST_IDLE;
         min_d   = 8'd0;
         sec_d   = 6'd0;
         presc_d = '0;
      end else if (load_ok) begin
         state_d = ST_IDLE;
         min_d   = load_minutes;
         sec_d   = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
         presc_d = '0;
      end else if (stop) begin
         // Prescaler is deliberately held so a resume keeps partial-second progress.
         if (state_q == ST_RUNNING) begin
            state_d = ST_PAUSED;
         end
      end else if (start_ok) begin
         state_d = ST_RUNNING;
      end else if (state_q == ST_RUNNING) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            if (sec_q != 6'd0) begin
               sec_d = sec_q - 6'd1;
            end else if (min_q != 8'd0) begin
               sec_d = 6'd59;
               min_d = min_q - 8'd1;
            end
            if ((min_q == 8'd0) && (sec_q == 6'd1)) begin
               state_d = ST_EXPIRED;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         min_q   <= 8'd0;
         sec_q   <= 6'd0;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

   assign minutes = min_q;
   assign seconds = sec_q;
   assign status  = state_q;
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a 1-clock/second and a 4-clock/second instance share stimulus;
// expected outputs are queued with each step and compared after the following edge.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst, load, start, stop, clear;
   logic [7:0] load_minutes;
   logic [5:0] load_seconds;

   logic [7:0] min1, min4;
   logic [5:0] sec1, sec4;
   logic [1:0] st1, st4;
   logic       dn1, dn4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      bit         sel;
      logic [7:0] m;
      logic [5:0] s;
      logic [1:0] st;
      logic       dn;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   countdown_timer #(.CLKS_PER_SEC(1)) u_fast (
      .clk(clk), .rst(rst), .load(load), .load_minutes(load_minutes),
      .load_seconds(load_seconds), .start(start), .stop(stop), .clear(clear),
      .minutes(min1), .seconds(sec1), .status(st1), .done(dn1)
   );

   countdown_timer #(.CLKS_PER_SEC(4)) u_slow (
      .clk(clk), .rst(rst), .load(load), .load_minutes(load_minutes),
      .load_seconds(load_seconds), .start(start), .stop(stop), .clear(clear),
      .minutes(min4), .seconds(sec4), .status(st4), .done(dn4)
   );

   task automatic expect_out(input string tag, input bit sel, input int m, input int s,
                             input int st, input bit dn);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.m   = 8'(m);
      e.s   = 6'(s);
      e.st  = 2'(st);
      e.dn  = dn;
      sb.push_back(e);
   endtask

   task automatic check_outputs();
      exp_t       e;
      logic [7:0] om;
      logic [5:0] os;
      logic [1:0] ost;
      logic       odn;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         om  = e.sel ? min4 : min1;
         os  = e.sel ? sec4 : sec1;
         ost = e.sel ? st4  : st1;
         odn = e.sel ? dn4  : dn1;
         checks++;
         assert (om === e.m) else begin
            errors++;
            $error("FAIL %s minutes: observed %0d expected %0d", e.tag, om, e.m);
         end
         checks++;
         assert (os === e.s) else begin
            errors++;
            $error("FAIL %s seconds: observed %0d expected %0d", e.tag, os, e.s);
         end
         checks++;
         assert (ost === e.st) else begin
            errors++;
            $error("FAIL %s status: observed %b expected %b", e.tag, ost, e.st);
         end
         checks++;
         assert (odn === e.dn) else begin
            errors++;
            $error("FAIL %s done: observed %b expected %b", e.tag, odn, e.dn);
         end
      end
   endtask

   // One clock edge, then compare everything queued for it.
   task automatic step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   task automatic do_load(input int m, input int s);
      load_minutes = 8'(m);
      load_seconds = 6'(s);
      load = 1'b1;
   endtask

   initial begin
      idle_inputs();
      load_minutes = 8'd0;
      load_seconds = 6'd0;

      // Reset
      rst = 1'b1;
      expect_out("reset_fast", 0, 0, 0, 0, 0);
      expect_out("reset_slow", 1, 0, 0, 0, 0);
      step();
      idle_inputs();

      // Basic countdown 00:03
      do_load(0, 3);
      expect_out("basic_load", 0, 0, 3, 0, 0);
      step();
      idle_inputs(); start = 1'b1;
      expect_out("basic_start", 0, 0, 3, 1, 0);
      step();
      idle_inputs();
      expect_out("basic_t1", 0, 0, 2, 1, 0); step();
      expect_out("basic_t2", 0, 0, 1, 1, 0); step();
      expect_out("basic_exp", 0, 0, 0, 3, 1); step();
      expect_out("basic_done_drop", 0, 0, 0, 3, 0); step();
      expect_out("basic_hold", 0, 0, 0, 3, 0); step();

      // Borrow 02:00
      do_load(2, 0);
      expect_out("borrow_load", 0, 2, 0, 0, 0);
      step();
      idle_inputs(); start = 1'b1;
      step();
      idle_inputs();
      expect_out("borrow_1", 0, 1, 59, 1, 0); step();
      run(58);
      expect_out("borrow_60", 0, 1, 0, 1, 0); step();
      expect_out("borrow_61", 0, 0, 59, 1, 0); step();
      run(57);
      expect_out("borrow_119", 0, 0, 1, 1, 0); step();
      expect_out("borrow_120", 0, 0, 0, 3, 1); step();

      // Prescaler and pause on the 4-clock instance
      do_load(0, 2);
      expect_out("pre_load", 1, 0, 2, 0, 0);
      step();
      idle_inputs(); start = 1'b1;
      expect_out("pre_start", 1, 0, 2, 1, 0);
      step();
      idle_inputs();
      run(2);
      stop = 1'b1;
      expect_out("pre_stop", 1, 0, 2, 2, 0);
      step();
      idle_inputs();
      run(9);
      expect_out("pre_paused", 1, 0, 2, 2, 0); step();
      start = 1'b1;
      expect_out("pre_resume", 1, 0, 2, 1, 0);
      step();
      idle_inputs();
      expect_out("pre_run3", 1, 0, 2, 1, 0); step();
      expect_out("pre_run4", 1, 0, 1, 1, 0); step();
      run(3);
      expect_out("pre_run8", 1, 0, 0, 3, 1); step();

      // Ignored controls
      clear = 1'b1;
      expect_out("ign_clear", 0, 0, 0, 0, 0);
      step();
      idle_inputs(); start = 1'b1;
      expect_out("ign_start_zero", 0, 0, 0, 0, 0);
      step();
      idle_inputs(); do_load(0, 5);
      step();
      idle_inputs(); start = 1'b1;
      expect_out("ign_start_ok", 0, 0, 5, 1, 0);
      step();
      idle_inputs(); do_load(0, 30);
      expect_out("ign_load_running", 0, 0, 4, 1, 0);
      step();
      idle_inputs(); start = 1'b1; stop = 1'b1;
      expect_out("ign_startstop_run", 0, 0, 4, 2, 0);
      step();
      expect_out("ign_startstop_pause", 0, 0, 4, 2, 0);
      step();
      idle_inputs();

      // Saturation and priority
      do_load(1, 63);
      expect_out("sat_seconds", 0, 1, 59, 0, 0);
      step();
      do_load(3, 10); clear = 1'b1;
      expect_out("prio_clear_load", 0, 0, 0, 0, 0);
      step();
      idle_inputs();

      // Mid-count reset
      do_load(0, 7);
      step();
      idle_inputs(); start = 1'b1;
      step();
      idle_inputs();
      run(1);
      expect_out("mid_pre_rst", 0, 0, 5, 1, 0); step();
      rst = 1'b1;
      expect_out("mid_rst", 0, 0, 0, 0, 0);
      step();
      idle_inputs(); do_load(0, 1);
      step();
      idle_inputs(); start = 1'b1;
      step();
      idle_inputs();
      expect_out("mid_rerun", 0, 0, 0, 3, 1); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
